// File: rtl/piso_pkg.sv
// Shared types and frame-geometry helpers for the PISO transmitter.
// Frame length depends on the PISO_PARITY_EN build option.
package piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(frame_len(width));
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: reloads on accept, advances per sent bit and
// raises a registered terminal-count flag on the final frame bit.
module piso_bit_counter #(
  parameter int FRAME_LEN = 4,
  parameter int CW        = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (load_i) begin
      cnt_d = '0;
      tc_d  = (LAST == '0);
    end else if (clr_i) begin
      cnt_d = '0;
      tc_d  = 1'b0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
      tc_d  = (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, valid/ready input and
// per-bit stall via tx_en. Define PISO_PARITY_EN to append an even-parity bit.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin_valid,
  input  logic [WIDTH-1:0] pin,
  output logic             pin_ready,
  input  logic             tx_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CW        = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cnt_load, cnt_en, cnt_clr;
  logic             last_bit;
  logic             accept;
  logic             fill_bit;

  // The parity bit rides in the shift register MSB so it leaves right after pin[WIDTH-1].
`ifdef PISO_PARITY_EN
  assign fill_bit = ^pin;
`else
  assign fill_bit = 1'b0;
`endif

  assign pin_ready = (state_q == IDLE) || ((state_q == SHIFT) && last_bit && tx_en);
  assign accept    = pin_valid && pin_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    sout_d   = sout_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    if (accept) begin
      sout_d   = pin[0];
      shreg_d  = {fill_bit, pin[WIDTH-1:1]};
      valid_d  = 1'b1;
      busy_d   = 1'b1;
      state_d  = SHIFT;
      cnt_load = 1'b1;
    end else if ((state_q == SHIFT) && tx_en) begin
      if (last_bit) begin
        state_d = IDLE;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
      end else begin
        sout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_en  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  piso_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .tc_o   (last_bit)
  );

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_bit;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4), parity-aware.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic       clk;
  logic       rst;
  logic       pin_valid;
  logic [3:0] pin;
  logic       pin_ready;
  logic       tx_en;
  logic       sout;
  logic       sout_valid;
  logic       sout_last;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] sipo;

  piso_tx #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_valid  (pin_valid),
    .pin        (pin),
    .pin_ready  (pin_ready),
    .tx_en      (tx_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "/sout"},       32'(sout),       32'd0);
    check({tag, "/sout_valid"}, 32'(sout_valid), 32'd0);
    check({tag, "/sout_last"},  32'(sout_last),  32'd0);
    check({tag, "/busy"},       32'(busy),       32'd0);
    check({tag, "/pin_ready"},  32'(pin_ready),  32'd1);
  endtask

  // Called just after the accept edge; seq[i] is the i-th bit expected on sout.
  task automatic run_frame(input string tag, input logic [4:0] seq, input int stall_at);
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("%s/bit%0d", tag, i),   32'(sout),       32'(seq[i]));
      check($sformatf("%s/valid%0d", tag, i), 32'(sout_valid), 32'd1);
      check($sformatf("%s/last%0d", tag, i),  32'(sout_last),  32'(i == FLEN - 1));
      check($sformatf("%s/busy%0d", tag, i),  32'(busy),       32'd1);
      check($sformatf("%s/ready%0d", tag, i), 32'(pin_ready),  32'(i == FLEN - 1));
      if (i < 4) sipo = {sout, sipo[3:1]};
      if (i == stall_at) begin
        tx_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check($sformatf("%s/stall_bit%0d", tag, k),   32'(sout),       32'(seq[i]));
          check($sformatf("%s/stall_valid%0d", tag, k), 32'(sout_valid), 32'd1);
          check($sformatf("%s/stall_ready%0d", tag, k), 32'(pin_ready),  32'd0);
        end
        tx_en = 1'b1;
      end
      if (i < FLEN - 1) tick();
    end
    $display("frame %s: %0d bits checked", tag, FLEN);
  endtask

  initial begin
    rst       = 1'b0;
    pin_valid = 1'b0;
    pin       = 4'h0;
    tx_en     = 1'b0;
    sipo      = 4'h0;

    #10;
    idle_chk("rst_hold");
    #2;
    rst = 1'b1;
    tick();
    idle_chk("idle");

    // Basic frame 1011: bits 1,1,0,1 then parity 1.
    pin = 4'b1011; pin_valid = 1'b1; tx_en = 1'b1;
    #1;
    check("f1/ready_pre", 32'(pin_ready), 32'd1);
    tick();
    pin_valid = 1'b0;
    run_frame("f1011", 5'b11011, -1);
    tick();
    idle_chk("f1011_end");

    // Round trip into a right-shifting 4-bit SIPO.
    sipo = 4'h0;
    pin = 4'b0110; pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
    run_frame("f0110", 5'b00110, -1);
    check("roundtrip/sipo", 32'(sipo), 32'h6);
    tick();
    idle_chk("f0110_end");

    // Back-to-back A then 5 with no idle bit between them.
    pin = 4'hA; pin_valid = 1'b1;
    tick();
    pin = 4'h5;
    run_frame("fA", 5'b01010, -1);
    tick();
    pin_valid = 1'b0;
    run_frame("f5", 5'b00101, -1);
    tick();
    idle_chk("b2b_end");

    // Stall for 3 cycles while bit 1 is on the line.
    pin = 4'b1100; pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
    run_frame("f1100", 5'b01100, 1);
    tick();
    idle_chk("stall_end");

    // Reset after two bits, then a fresh frame.
    pin = 4'b1111; pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    idle_chk("midrst");
    tick();
    idle_chk("midrst_hold");
    rst = 1'b1;
    pin = 4'b0001; pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
    run_frame("f0001", 5'b10001, -1);
    tick();
    idle_chk("f0001_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter; the counterpart of the team's 4-bit SIPO receiver.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, LSB first.
- The bit order matches the SIPO's right-shift fill, so WIDTH bits into the SIPO rebuild the word.
- Sits between a parallel data source and any serial-input shift register; per-bit stall via tx_en.

Parameters:
- WIDTH, 4, data word width in bits; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- pin_valid  input  1  source presents a word on pin
- pin  input  WIDTH  parallel word to transmit
- pin_ready  output  1  block can accept a word this cycle
- tx_en  input  1  consumer advance enable; low stalls the serial stream
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit
- sout_last  output  1  sout carries the final bit of the frame
- busy  output  1  a frame is in progress

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-low.
- Reset (rst=0), any time including mid-frame:
  - state=IDLE; shreg=0; bit counter=0.
  - sout=0, sout_valid=0, sout_last=0, busy=0.
  - Any partial frame is dropped; nothing resumes after reset.
- FSM states are IDLE and SHIFT.
- pin_ready is combinational from registered state:
  - pin_ready = (state==IDLE) OR (state==SHIFT AND sout_last AND tx_en).
- Accept occurs on a rising edge with pin_valid AND pin_ready. On accept:
  - sout<=pin[0]; shreg<=pin>>1; cnt<=0.
  - sout_valid<=1; sout_last<=(FRAME_LEN==1) (never true for WIDTH≥2); busy<=1.
  - state<=SHIFT.
- Latency: the first bit appears on sout in the cycle after accept.
- SHIFT with tx_en=1: sout<=shreg[0]; shreg<=shreg>>1; cnt<=cnt+1; sout_last<=(cnt+1==FRAME_LEN-1).
- SHIFT with tx_en=0: all registers hold and sout stays stable. The consumer samples only while tx_en=1.
- End of frame: the cycle with sout_last=1 and tx_en=1 completes the frame.
  - With pin_valid=1 in that cycle, the next word is accepted. Frames run back-to-back with no idle bit.
  - Otherwise: state<=IDLE; sout_valid<=0; sout_last<=0; busy<=0; sout<=0.
- pin_valid while pin_ready=0 is ignored. The source must hold pin and pin_valid until accepted.
- Frame length: FRAME_LEN = WIDTH, or WIDTH+1 when parity is compiled in.
  - Frame occupies exactly FRAME_LEN tx_en-high cycles.
  - Counter width is clog2(FRAME_LEN). The counter never wraps; it is reloaded on accept.
- tx_en has no effect in IDLE.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - On accept, even parity (XOR of all pin bits) is latched.
  - It is sent as one extra bit after pin[WIDTH-1].
  - sout_last marks the parity bit; FRAME_LEN=WIDTH+1.
- Undefined: no parity logic; FRAME_LEN=WIDTH and sout_last marks pin[WIDTH-1].

Decomposition:
- Package piso_pkg holds:
  - state enum {IDLE, SHIFT};
  - default WIDTH constant;
  - function computing FRAME_LEN and counter width.
- One natural sub-module: piso_bit_counter.
  - Loadable up-counter with enable.
  - Terminal-count flag drives sout_last.
- Shift register and FSM stay in piso_tx.

Test Plan:
- Reset then idle: rst=0 for 10ns, then 1 → sout=0, sout_valid=0, busy=0, pin_ready=1.
- WIDTH=4, pin=4'b1011, one-cycle valid, tx_en=1 → sout=1,1,0,1 on 4 consecutive cycles; sout_last on the 4th; then idle, busy=0.
- Round-trip: feed sout into a 4-bit right-shifting SIPO (sin enters MSB) for 4 clocks with pin=4'b0110 → SIPO register reads 4'b0110.
- Back-to-back: 4'hA then 4'h5 with pin_valid held → 8 consecutive valid bits 0,1,0,1,1,0,1,0; pin_ready high only on the last bit of frame 1.
- Stall: pin=4'b1100, tx_en=0 for 3 cycles after bit 1 → sout holds 0 during stall, frame completes 3 cycles late, bit order unchanged.
- Reset mid-frame (rst low after 2 bits), then reassert and send 4'b0001 → outputs clear immediately; new frame 1,0,0,0; PISO_PARITY_EN build adds a 5th bit=1.
